// File: rtl/ps2_keymap.sv
// PS/2 scan-code decoder with a writable key map that produces a held-key bitmap and press/release pulses.
// Latency: 1 cycle from terminal byte to outputs. No backpressure: it accepts one byte per clock.
module ps2_keymap #(
   parameter int NUM_KEYS       = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   localparam int AW            = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          byte_data,
   input  logic                byte_valid,
   input  logic                cfg_we,
   input  logic [AW-1:0]       cfg_addr,
   input  logic [8:0]          cfg_code,
   output logic [NUM_KEYS-1:0] keys_held,
   output logic [NUM_KEYS-1:0] key_pressed,
   output logic [NUM_KEYS-1:0] key_released,
   output logic                changed
);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_SKIP
   } state_t;

   function automatic logic [8:0] default_code(input int idx);
      case (idx)
         0:       return 9'h01A;
         1:       return 9'h022;
         2:       return 9'h05A;
         3:       return 9'h012;
         4:       return 9'h174;
         5:       return 9'h16B;
         6:       return 9'h172;
         7:       return 9'h175;
         default: return 9'h000;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [2:0]          skip_cnt_q, skip_cnt_d;
   logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic [8:0]          map_q [NUM_KEYS];
   logic [8:0]          map_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [NUM_KEYS-1:0] pressed_q, pressed_d;
   logic [NUM_KEYS-1:0] released_q, released_d;
   logic                changed_q, changed_d;

   logic                term_vld;
   logic                term_make;
   logic [8:0]          term_code;

   always_comb begin
      state_d    = state_q;
      skip_cnt_d = skip_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      term_vld   = 1'b0;
      term_make  = 1'b0;
      term_code  = 9'h000;

      if (byte_valid) begin
         tmo_cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               case (byte_data)
                  8'hE0: state_d = ST_EXT;
                  8'hF0: state_d = ST_BRK;
                  8'hE1: begin
                     state_d    = ST_SKIP;
                     skip_cnt_d = 3'd7;
                  end
                  8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_d = ST_IDLE;
                  default: begin
                     term_vld  = 1'b1;
                     term_make = 1'b1;
                     term_code = {1'b0, byte_data};
                  end
               endcase
            end
            ST_EXT: begin
               if (byte_data == 8'hF0) begin
                  state_d = ST_EXT_BRK;
               end else if (byte_data != 8'hE0) begin
                  state_d   = ST_IDLE;
                  term_vld  = 1'b1;
                  term_make = 1'b1;
                  term_code = {1'b1, byte_data};
               end
            end
            ST_BRK: begin
               state_d   = ST_IDLE;
               term_vld  = 1'b1;
               term_code = {1'b0, byte_data};
            end
            ST_EXT_BRK: begin
               state_d   = ST_IDLE;
               term_vld  = 1'b1;
               term_code = {1'b1, byte_data};
            end
            ST_SKIP: begin
               skip_cnt_d = skip_cnt_q - 3'd1;
               if (skip_cnt_q == 3'd1) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         // Abandon a stalled prefix; a byte arriving in this same cycle takes the branch above instead.
         if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = ST_IDLE;
            tmo_cnt_d  = '0;
            skip_cnt_d = 3'd0;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
         end
      end
   end

   always_comb begin
      held_d = held_q;
      map_d  = map_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (term_vld && (map_q[i][7:0] != 8'h00) && (map_q[i] == term_code)) begin
            held_d[i] = term_make;
         end
      end
      // The config write lands after matching so its clear overrides a same-cycle make.
      if (cfg_we && ({1'b0, cfg_addr} < (AW + 1)'(NUM_KEYS))) begin
         map_d[cfg_addr]  = cfg_code;
         held_d[cfg_addr] = 1'b0;
      end
      pressed_d  = held_d & ~held_q;
      released_d = ~held_d & held_q;
      changed_d  = |(pressed_d | released_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         skip_cnt_q <= 3'd0;
         tmo_cnt_q  <= '0;
         held_q     <= '0;
         pressed_q  <= '0;
         released_q <= '0;
         changed_q  <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            map_q[i] <= default_code(i);
         end
      end else begin
         state_q    <= state_d;
         skip_cnt_q <= skip_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         held_q     <= held_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         changed_q  <= changed_d;
         map_q      <= map_d;
      end
   end

   assign keys_held    = held_q;
   assign key_pressed  = pressed_q;
   assign key_released = released_q;
   assign changed      = changed_q;
endmodule

// File: doc/ps2_keymap.md
# ps2_keymap

Parametrised PS/2 scan-code decoder that turns the byte stream from the PS/2 receiver into a held-key bitmap for game input. It properly handles the E0 extended prefix, the F0 break prefix and the E1 Pause sequence. It uses a run-time writable key map of NUM_KEYS entries and emits per-key press/release pulses plus a change strobe. It sits between the PS/2 byte receiver and the CPU-visible input register.

## Interface
- NUM_KEYS, 8: number of mapped keys (1..32); width of all key vectors.
- TIMEOUT_CYCLES, 50000: idle clocks after which a partial prefix sequence is abandoned (1 ms at 50 MHz).
- AW, $clog2(NUM_KEYS) (minimum 1): map address width; derived, not overridden.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- byte_data  in  8  received scan-code byte.
- byte_valid  in  1  one-cycle strobe; byte_data is valid this cycle.
- cfg_we  in  1  map write enable.
- cfg_addr  in  AW  map entry index; values ≥ NUM_KEYS are ignored.
- cfg_code  in  9  {extended bit, scan code} for the entry.
- keys_held  out  NUM_KEYS  bit i is 1 while mapped key i is down.
- key_pressed  out  NUM_KEYS  one-cycle pulse on a 0→1 transition of keys_held[i].
- key_released  out  NUM_KEYS  one-cycle pulse on a 1→0 transition of keys_held[i].
- changed  out  1  OR of key_pressed and key_released, registered alongside them.

## Operation
- Map: NUM_KEYS registers of 9 bits each.
  - Reset defaults for entries 0..7: Z{0,1A}, X{0,22}, Enter{0,5A}, LShift{0,12}, Right{1,74}, Left{1,6B}, Down{1,72}, Up{1,75}.
  - Entries ≥ 8 reset to {0,00}.
  - Scan code 00 never matches.
- Parser FSM, advanced only on byte_valid:
  - IDLE:
    - E0 → EXT; F0 → BRK; E1 → SKIP with skip_cnt = 7.
    - AA, FA, FE, EE, 00 and FF are ignored and stay in IDLE.
    - Any other byte is a make for code {0,b}; go to IDLE.
  - EXT: F0 → EXT_BRK; E0 stays in EXT; any other byte is a make for {1,b} → IDLE.
  - BRK: any byte is a break for {0,b} → IDLE.
  - EXT_BRK: any byte is a break for {1,b} → IDLE.
  - SKIP: decrement skip_cnt on each byte; go to IDLE after the 7th byte. No key effect.
- Matching:
  - The terminal code is compared against every entry in parallel; all matching entries update.
  - Make sets keys_held[i]. Break clears keys_held[i].
  - Typematic repeat (make while already held) gives no pulse. A break for a key not held gives no pulse.
- Timeout:
  - In any state other than IDLE, a counter increments each cycle without byte_valid and resets on byte_valid.
  - When it reaches TIMEOUT_CYCLES−1, the FSM returns to IDLE and no key is affected.
  - If byte_valid arrives in the expiry cycle, the byte wins and is processed in the current state.
- Config write:
  - Entry cfg_addr gets cfg_code on the next edge.
  - The same edge clears keys_held[cfg_addr]; if that bit was 1, key_released[cfg_addr] pulses.
  - If cfg_we and a terminal byte arrive in the same cycle, matching uses the old map contents; the write then applies, and the write's clear wins for that entry.

## Timing
- Reset values:
  - keys_held, key_pressed, key_released and changed are all 0.
  - FSM is in IDLE; timeout and skip counters are 0.
  - Map holds its defaults.
- Reset mid-sequence discards the partial prefix. Held keys are cleared without release pulses.
- A terminal byte with byte_valid in cycle N gives updated keys_held at edge N+1. key_pressed, key_released and changed are high during cycle N+1 only.
- Prefix bytes (E0, F0, E1) produce no output change.
- Back-to-back byte_valid on consecutive cycles is supported at full rate, one byte per clock.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Bytes 1A, then F0 1A → keys_held[0]=1 with key_pressed[0]=1 and changed=1 one cycle after 1A; then keys_held[0]=0 with key_released[0]=1 one cycle after the second 1A.
- E0 75, then 75, then E0 F0 75 → first byte pair sets keys_held[7]. The non-extended 75 (keypad 8) has no effect. E0 F0 75 clears keys_held[7].
- 1A 1A 1A (typematic) → key_pressed[0] pulses exactly once. F0 22 with X not held → no pulse and keys_held unchanged.
- E1 14 77 E1 F0 14 F0 77, then 1A → keys_held stays 0 through the Pause sequence; bit 0 sets after the final 1A.
- E0, then 50000 idle cycles, then 6B → {1,6B} is not decoded. The byte is treated as make {0,6B}, which matches no default entry, so keys_held stays 0.
- cfg write addr 0 = {0,1C} while Z is held → key_released[0] pulses. Then 1C → keys_held[0]=1, and 1A → no effect.
